// File: rtl/sm_add_sub_pipe.sv
// sm_add_sub_pipe: two-stage elastic sign-magnitude adder/subtractor.
// Operands go to two's complement in S1, are summed and converted back in S2.
module sm_add_sub_pipe #(
  parameter int MAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             operation,
  input  logic [MAG_W:0]   a,
  input  logic [MAG_W:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W+1:0] c,
  output logic             zero
);

  localparam int W = MAG_W + 2;

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;

  logic         s1_load;
  logic         s2_load;

  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [W-1:0] a_tc;
  logic [W-1:0] b_tc;

  logic [W-1:0] sum;
  logic         sum_neg;
  logic [MAG_W:0] sum_lo;
  logic [MAG_W:0] sum_mag;
  logic         sum_zero;

  // S2 frees up when empty or draining; S1 when empty or moving into S2.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !rst && s1_load;

  // Operand conversion; -0 negates to 0, and subtract flips B's sign.
  always_comb begin
    a_ext = {2'b00, a[MAG_W-1:0]};
    b_ext = {2'b00, b[MAG_W-1:0]};
    a_tc  = a[MAG_W] ? -a_ext : a_ext;
    b_tc  = (b[MAG_W] ^ operation) ? -b_ext : b_ext;
  end

  // Sum and convert back; the sum never reaches -2^(W-1), so the
  // low MAG_W+1 bits of the negation hold the full magnitude.
  always_comb begin
    sum      = s1_a + s1_b;
    sum_neg  = sum[W-1];
    sum_lo   = sum[MAG_W:0];
    sum_mag  = sum_neg ? -sum_lo : sum_lo;
    sum_zero = (sum == '0);
  end

  // S1 register: captures converted operands on an input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= a_tc;
        s1_b <= b_tc;
      end
    end
  end

  // S2 register: result holds stable while stalled downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      zero      <= 1'b1;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        c    <= {sum_neg, sum_mag};
        zero <= sum_zero;
      end
    end
  end

endmodule

// File: tb/tb_sm_add_sub_pipe.sv
// tb_sm_add_sub_pipe: directed and exhaustive-random checks of the
// sign-magnitude add/sub pipeline at MAG_W = 2, 1 and 4.
module tb_sm_add_sub_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       operation = 1'b0;
  logic [2:0] a = '0;
  logic [2:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] c;
  logic       zero;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic       op1 = 1'b0;
  logic [1:0] a1 = '0;
  logic [1:0] b1 = '0;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;
  logic [2:0] c1;
  logic       zero1;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic       op4 = 1'b0;
  logic [4:0] a4 = '0;
  logic [4:0] b4 = '0;
  logic       out_valid4;
  logic       out_ready4 = 1'b0;
  logic [5:0] c4;
  logic       zero4;

  sm_add_sub_pipe #(.MAG_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .zero(zero)
  );

  sm_add_sub_pipe #(.MAG_W(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .operation(op1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .c(c1), .zero(zero1)
  );

  sm_add_sub_pipe #(.MAG_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .operation(op4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .c(c4), .zero(zero4)
  );

  // Reference: packs {zero, sign, magnitude} from plain integer math.
  function automatic int ref_model(input int w, input int op,
                                   input int sa, input int ma,
                                   input int sb, input int mb);
    int va;
    int vb;
    int r;
    int s;
    int m;
    int z;
    va = (sa != 0) ? -ma : ma;
    vb = (sb != 0) ? -mb : mb;
    r  = (op != 0) ? va - vb : va + vb;
    s  = (r < 0) ? 1 : 0;
    m  = (r < 0) ? -r : r;
    z  = (r == 0) ? 1 : 0;
    return (z << (w + 2)) | (s << (w + 1)) | m;
  endfunction

  task automatic apply(input logic o, input logic [2:0] x,
                       input logic [2:0] y);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    operation = o;
    a = x;
    b = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready_during_rst got=%b want=0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, c, zero} !== 6'b0_0000_1) begin
      bad++;
      $display("FAIL reset_state got=%b%b%b want=000001",
               out_valid, c, zero);
    end
    total++;
    if ({in_ready, in_ready1, in_ready4} !== 3'b111) begin
      bad++;
      $display("FAIL reset_in_ready got=%b%b%b want=111",
               in_ready, in_ready1, in_ready4);
    end
    total++;
    if ({out_valid1, out_valid4} !== 2'b00) begin
      bad++;
      $display("FAIL reset_out_valid_w14 got=%b%b want=00",
               out_valid1, out_valid4);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    operation = 1'b0;
    a = 3'b001;
    b = 3'b010;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early got=%b want=0", out_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, c, zero} !== 6'b1_0011_0) begin
      bad++;
      $display("FAIL latency_result got=%b%b%b want=100110",
               out_valid, c, zero);
    end
  endtask

  task automatic test_add_cancel();
    apply(1'b0, 3'b011, 3'b111);
    total++;
    if ({out_valid, c, zero} !== 6'b1_0000_1) begin
      bad++;
      $display("FAIL add_cancel got=%b%b%b want=100001",
               out_valid, c, zero);
    end
  endtask

  task automatic test_sub_opposite();
    apply(1'b1, 3'b011, 3'b111);
    total++;
    if ({out_valid, c, zero} !== 6'b1_0110_0) begin
      bad++;
      $display("FAIL sub_opposite got=%b%b%b want=101100",
               out_valid, c, zero);
    end
  endtask

  task automatic test_negative_result();
    apply(1'b1, 3'b111, 3'b011);
    total++;
    if ({out_valid, c, zero} !== 6'b1_1110_0) begin
      bad++;
      $display("FAIL negative_result got=%b%b%b want=111100",
               out_valid, c, zero);
    end
  endtask

  task automatic test_negative_zero();
    apply(1'b0, 3'b100, 3'b100);
    total++;
    if ({out_valid, c, zero} !== 6'b1_0000_1) begin
      bad++;
      $display("FAIL neg_zero_add got=%b%b%b want=100001",
               out_valid, c, zero);
    end
    apply(1'b1, 3'b100, 3'b000);
    total++;
    if ({out_valid, c, zero} !== 6'b1_0000_1) begin
      bad++;
      $display("FAIL neg_zero_sub got=%b%b%b want=100001",
               out_valid, c, zero);
    end
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    operation = 1'b0;
    a = 3'b001;
    b = 3'b001;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept0 got=%b want=1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a = 3'b010;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept1 got=%b want=1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a = 3'b011;
    #1;
    total++;
    if ({in_ready, out_valid, c} !== 6'b0_1_0010) begin
      bad++;
      $display("FAIL bp_full got=%b%b%b want=010010",
               in_ready, out_valid, c);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, c, zero} !== 7'b0_1_0010_0) begin
      bad++;
      $display("FAIL bp_hold got=%b%b%b%b want=0100100",
               in_ready, out_valid, c, zero);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, c} !== 6'b1_1_0010) begin
      bad++;
      $display("FAIL bp_release got=%b%b%b want=110010",
               in_ready, out_valid, c);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, c} !== 5'b1_0011) begin
      bad++;
      $display("FAIL bp_second got=%b%b want=10011", out_valid, c);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({out_valid, c} !== 5'b1_0100) begin
      bad++;
      $display("FAIL bp_third got=%b%b want=10100", out_valid, c);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drained got=%b want=0", out_valid);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    operation = 1'b0;
    a = 3'b001;
    b = 3'b001;
    @(posedge clk);
    @(negedge clk);
    a = 3'b010;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    a = 3'b011;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, c, zero, in_ready} !== 7'b0_0000_1_1) begin
      bad++;
      $display("FAIL rst_inflight got=%b%b%b%b want=0000011",
               out_valid, c, zero, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_input_dropped got=%b want=0", out_valid);
    end
  endtask

  task automatic test_exhaustive_w1();
    int q[$];
    int n;
    int idx;
    int cyc;
    int ev;
    int ai;
    int bi;
    n = 2 * 4 * 4;
    idx = 0;
    cyc = 0;
    while ((idx < n || q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready1 = 1'($urandom_range(0, 1));
      ai = (idx / 2) % 4;
      bi = idx / 8;
      in_valid1 = (idx < n) && ($urandom_range(0, 3) != 0);
      op1 = 1'(idx % 2);
      a1 = ai[1:0];
      b1 = bi[1:0];
      #1;
      if (out_valid1 && out_ready1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL w1_extra got=%b%b want=none", zero1, c1);
        end else begin
          ev = q.pop_front();
          if ({zero1, c1} !== ev[3:0]) begin
            bad++;
            $display("FAIL w1_result got=%b%b want=%b",
                     zero1, c1, ev[3:0]);
          end
        end
      end
      if (in_valid1 && in_ready1) begin
        q.push_back(ref_model(1, idx % 2, ai / 2, ai % 2,
                              bi / 2, bi % 2));
        idx++;
      end
    end
    in_valid1 = 1'b0;
    total++;
    if (idx < n || q.size() > 0) begin
      bad++;
      $display("FAIL w1_timeout got=%0d/%0d pending=%0d want=all",
               idx, n, q.size());
    end
  endtask

  task automatic test_exhaustive_w4();
    int q[$];
    int n;
    int idx;
    int cyc;
    int ev;
    int ai;
    int bi;
    n = 2 * 32 * 32;
    idx = 0;
    cyc = 0;
    while ((idx < n || q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready4 = 1'($urandom_range(0, 1));
      ai = (idx / 2) % 32;
      bi = idx / 64;
      in_valid4 = (idx < n) && ($urandom_range(0, 3) != 0);
      op4 = 1'(idx % 2);
      a4 = ai[4:0];
      b4 = bi[4:0];
      #1;
      if (out_valid4 && out_ready4) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL w4_extra got=%b%b want=none", zero4, c4);
        end else begin
          ev = q.pop_front();
          if ({zero4, c4} !== ev[6:0]) begin
            bad++;
            $display("FAIL w4_result got=%b%b want=%b",
                     zero4, c4, ev[6:0]);
          end
        end
      end
      if (in_valid4 && in_ready4) begin
        q.push_back(ref_model(4, idx % 2, ai / 16, ai % 16,
                              bi / 16, bi % 16));
        idx++;
      end
    end
    in_valid4 = 1'b0;
    total++;
    if (idx < n || q.size() > 0) begin
      bad++;
      $display("FAIL w4_timeout got=%0d/%0d pending=%0d want=all",
               idx, n, q.size());
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_latency();
    test_add_cancel();
    test_sub_opposite();
    test_negative_result();
    test_negative_zero();
    test_back_pressure();
    test_reset_inflight();
    test_exhaustive_w1();
    test_exhaustive_w4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
